// File: rtl/wb_decoder_timeout_if.sv
// Bridge-to-decoder Wishbone bundle: master-side request/response plus the
// shared slave bus and per-slave strobe/ack lines.
interface wb_decoder_timeout_if;
   logic [35:0]  m_adr_i;
   logic [31:0]  m_dat_i;
   logic [31:0]  m_dat_o;
   logic         m_we_i;
   logic [3:0]   m_sel_i;
   logic         m_stb_i;
   logic         m_cyc_i;
   logic         m_ack_o;
   logic [35:0]  s_adr_o;
   logic [31:0]  s_dat_o;
   logic         s_we_o;
   logic [3:0]   s_sel_o;
   logic [3:0]   s_stb_o;
   logic [3:0]   s_cyc_o;
   logic [127:0] s_dat_i;
   logic [3:0]   s_ack_i;

   modport slave (
      input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o
   );

   modport master (
      output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o
   );
endinterface

// File: rtl/wb_decoder_timeout.sv
// Single-master Wishbone 4-way address decoder with bus watchdog.
// Optional error status registers enabled by `define WB_DECODER_STATUS_EN.
module wb_decoder_timeout #(
   parameter logic [3:0]  SLAVE_MASK     = 4'b1111,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
   input logic                 clk,
   input logic                 rst_n,
   wb_decoder_timeout_if.slave bus
`ifdef WB_DECODER_STATUS_EN
   ,
   output logic [15:0]         err_count,
   output logic [35:0]         last_err_adr,
   output logic                last_err_to,
   input  logic                err_clr
`endif
);

   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      ACTIVE = 5'b00010,
      ERROR  = 5'b00100,
      ACK    = 5'b01000,
      DRAIN  = 5'b10000
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [1:0]  idx;
   logic [15:0] cnt;
   logic        req;
   logic        ack_hit;

   assign req         = bus.m_cyc_i && bus.m_stb_i;
   assign bus.s_stb_o = (state == ACTIVE) ? (4'b0001 << idx) : '0;
   assign bus.s_cyc_o = bus.s_stb_o;

   always_comb begin
      state_nxt = state;
      ack_hit   = 1'b0;
      case (state)
         IDLE:
            if (req) state_nxt = SLAVE_MASK[bus.m_adr_i[35:34]] ? ACTIVE : ERROR;
         ACTIVE:
            if (!bus.m_cyc_i) begin
               state_nxt = IDLE;
            end else if (bus.s_ack_i[idx]) begin
               state_nxt = ACK;
               ack_hit   = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ERROR;
            end
         ERROR:   state_nxt = ACK;
         ACK:     state_nxt = DRAIN;
         DRAIN:
            if (!bus.m_stb_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // m_ack_o is registered off the ACK state, giving the +2 / +3 ack latencies
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         cnt         <= '0;
         bus.m_ack_o <= 1'b0;
         bus.m_dat_o <= '0;
         bus.s_adr_o <= '0;
         bus.s_dat_o <= '0;
         bus.s_we_o  <= 1'b0;
         bus.s_sel_o <= '0;
      end else begin
         state       <= state_nxt;
         bus.m_ack_o <= (state == ACK);
         cnt         <= (state == ACTIVE) ? cnt + 16'd1 : '0;
         if (state == IDLE && req) begin
            bus.s_adr_o <= bus.m_adr_i;
            bus.s_dat_o <= bus.m_dat_i;
            bus.s_we_o  <= bus.m_we_i;
            bus.s_sel_o <= bus.m_sel_i;
            idx         <= bus.m_adr_i[35:34];
         end
         if (ack_hit && !bus.s_we_o) bus.m_dat_o <= bus.s_dat_i[{idx, 5'b0} +: 32];
         if (state == ERROR && !bus.s_we_o) bus.m_dat_o <= ERR_DATA;
      end
   end

`ifdef WB_DECODER_STATUS_EN
   logic        err_entry;
   logic [35:0] err_adr;

   assign err_entry = (state_nxt == ERROR) && (state != ERROR);
   assign err_adr   = (state == IDLE) ? bus.m_adr_i : bus.s_adr_o;

   // a coinciding clear zeroes the count but still records the new error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count    <= '0;
         last_err_adr <= '0;
         last_err_to  <= 1'b0;
      end else begin
         if (err_entry) begin
            last_err_adr <= err_adr;
            last_err_to  <= (state == ACTIVE);
         end else if (err_clr) begin
            last_err_adr <= '0;
            last_err_to  <= 1'b0;
         end
         if (err_clr) err_count <= '0;
         else if (err_entry && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_decoder_timeout.sv
// Two decoders (all slaves populated / slaves 0-1 only) share one master stream;
// a transaction-level model predicts strobe windows, ack cycle and ack data.
module tb_wb_decoder_timeout;
   localparam int          T      = 8;
   localparam logic [3:0]  MASK_A = 4'b1111;
   localparam logic [3:0]  MASK_B = 4'b0011;
   localparam int          NEVER  = 1000;
   localparam logic [31:0] ERRD   = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [35:0] m_adr;
   logic [31:0] m_dat;
   logic        m_we;
   logic [3:0]  m_sel;
   logic        m_stb, m_cyc;
   logic [3:0]  ack_a = '0, ack_b = '0;
   logic [31:0] sw [4] = '{32'h00005A5A, 32'h11110001, 32'h2222ABCD, 32'hCAFEF00D};
   logic [127:0] sdat;

   always #5 clk = ~clk;
   assign sdat = {sw[3], sw[2], sw[1], sw[0]};

   wb_decoder_timeout_if bus_a ();
   wb_decoder_timeout_if bus_b ();

   assign bus_a.m_adr_i = m_adr;  assign bus_b.m_adr_i = m_adr;
   assign bus_a.m_dat_i = m_dat;  assign bus_b.m_dat_i = m_dat;
   assign bus_a.m_we_i  = m_we;   assign bus_b.m_we_i  = m_we;
   assign bus_a.m_sel_i = m_sel;  assign bus_b.m_sel_i = m_sel;
   assign bus_a.m_stb_i = m_stb;  assign bus_b.m_stb_i = m_stb;
   assign bus_a.m_cyc_i = m_cyc;  assign bus_b.m_cyc_i = m_cyc;
   assign bus_a.s_dat_i = sdat;   assign bus_b.s_dat_i = sdat;
   assign bus_a.s_ack_i = ack_a;  assign bus_b.s_ack_i = ack_b;

`ifdef WB_DECODER_STATUS_EN
   logic [15:0] ec_a, ec_b;
   logic [35:0] la_a, la_b;
   logic        lt_a, lt_b;
`endif

   wb_decoder_timeout #(.SLAVE_MASK(MASK_A), .TIMEOUT_CYCLES(T), .ERR_DATA(ERRD)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a)
`ifdef WB_DECODER_STATUS_EN
      , .err_count(ec_a), .last_err_adr(la_a), .last_err_to(lt_a), .err_clr(1'b0)
`endif
   );

   wb_decoder_timeout #(.SLAVE_MASK(MASK_B), .TIMEOUT_CYCLES(T), .ERR_DATA(ERRD)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b)
`ifdef WB_DECODER_STATUS_EN
      , .err_count(ec_b), .last_err_adr(la_b), .last_err_to(lt_b), .err_clr(1'b0)
`endif
   );

   int n_chk = 0, n_fail = 0;
   int cyc_n = 0;
   logic started = 1'b0;
   int dly = NEVER;

   // model expectations per DUT (index 0 = dut_a, 1 = dut_b)
   int          stb_s [2] = '{0, 0};
   int          stb_e [2] = '{0, 0};
   int          ack_c [2] = '{-1, -1};
   logic [3:0]  stb_v [2] = '{4'b0, 4'b0};
   logic [31:0] ack_d [2] = '{32'h0, 32'h0};
   logic [31:0] last_d [2] = '{32'h0, 32'h0};
   logic [35:0] cur_adr;
   logic [31:0] cur_dat;
   logic        cur_we;
   logic [3:0]  cur_sel;

   int          ackcnt [2] = '{0, 0};
   int          ack_at [2] = '{0, 0};
   logic [31:0] ack_dat [2] = '{32'h0, 32'h0};
   int          run_a [4] = '{0, 0, 0, 0};
   int          run_b [4] = '{0, 0, 0, 0};
   int          rise0_a = 0, hi1_a = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // slave responder: ack in strobe cycle dly+1 of the selected slave
   always @(negedge clk) begin
      for (int n = 0; n < 4; n++) begin
         ack_a[n] <= bus_a.s_stb_o[n] && (run_a[n] == dly);
         ack_b[n] <= bus_b.s_stb_o[n] && (run_b[n] == dly);
         run_a[n] <= bus_a.s_stb_o[n] ? run_a[n] + 1 : 0;
         run_b[n] <= bus_b.s_stb_o[n] ? run_b[n] + 1 : 0;
      end
      if (bus_a.s_stb_o[0] && run_a[0] == 0) rise0_a <= rise0_a + 1;
      if (bus_a.s_stb_o[1]) hi1_a <= hi1_a + 1;
   end

   task automatic check_dut(input int u, input logic [3:0] stb, input logic [3:0] cv,
                            input logic ack, input logic [31:0] dat, input logic [35:0] adr,
                            input logic [31:0] sd, input logic we, input logic [3:0] sel);
      logic [3:0] es;
      logic       ea;
      es = (cyc_n >= stb_s[u] && cyc_n < stb_e[u]) ? stb_v[u] : 4'b0;
      ea = (cyc_n == ack_c[u]);
      chk($sformatf("dut%0d s_stb_o", u), 64'(stb), 64'(es));
      chk($sformatf("dut%0d s_cyc_o", u), 64'(cv), 64'(es));
      chk($sformatf("dut%0d m_ack_o", u), 64'(ack), 64'(ea));
      if (ea) chk($sformatf("dut%0d m_dat_o", u), 64'(dat), 64'(ack_d[u]));
      if (es != 4'b0) begin
         chk($sformatf("dut%0d s_adr_o", u), 64'(adr), 64'(cur_adr));
         chk($sformatf("dut%0d s_dat_o", u), 64'(sd), 64'(cur_dat));
         chk($sformatf("dut%0d s_we_o", u), 64'(we), 64'(cur_we));
         chk($sformatf("dut%0d s_sel_o", u), 64'(sel), 64'(cur_sel));
      end
      if (ack) begin
         ackcnt[u]++;
         ack_at[u]  = cyc_n;
         ack_dat[u] = dat;
      end
   endtask

   always @(negedge clk) begin
      if (started && rst_n) begin
         check_dut(0, bus_a.s_stb_o, bus_a.s_cyc_o, bus_a.m_ack_o, bus_a.m_dat_o,
                   bus_a.s_adr_o, bus_a.s_dat_o, bus_a.s_we_o, bus_a.s_sel_o);
         check_dut(1, bus_b.s_stb_o, bus_b.s_cyc_o, bus_b.m_ack_o, bus_b.m_dat_o,
                   bus_b.s_adr_o, bus_b.s_dat_o, bus_b.s_we_o, bus_b.s_sel_o);
      end
   end

   task automatic rst_chk();
      chk("rst a m_ack_o", 64'(bus_a.m_ack_o), 64'(0));
      chk("rst a m_dat_o", 64'(bus_a.m_dat_o), 64'(0));
      chk("rst a s_stb_o", 64'(bus_a.s_stb_o), 64'(0));
      chk("rst a s_adr_o", 64'(bus_a.s_adr_o), 64'(0));
      chk("rst a s_dat_o", 64'(bus_a.s_dat_o), 64'(0));
      chk("rst a s_we_sel", 64'({bus_a.s_we_o, bus_a.s_sel_o}), 64'(0));
      chk("rst b m_ack_o", 64'(bus_b.m_ack_o), 64'(0));
      chk("rst b m_dat_o", 64'(bus_b.m_dat_o), 64'(0));
      chk("rst b s_stb_o", 64'(bus_b.s_stb_o), 64'(0));
      chk("rst b s_adr_o", 64'(bus_b.s_adr_o), 64'(0));
   endtask

   // rules: unpopulated -> ack +3 error data; slave ack in strobe cycle d+1 -> ack +d+3;
   // no ack within T strobe cycles -> ack +T+3 error data; writes keep old read data
   task automatic model_dut(input int u, input logic [3:0] mask, input int d, input int mode,
                            input int t0, output int k);
      int   i;
      logic pop;
      i   = int'(cur_adr[35:34]);
      pop = mask[i];
      stb_s[u] = t0;
      stb_v[u] = 4'b0001 << i;
      k        = 0;
      if (mode != 0) begin
         stb_e[u] = pop ? t0 + 3 : t0;
         ack_c[u] = -1;
         if (mode == 2) last_d[u] = 32'h0;
         return;
      end
      if (!pop) begin
         stb_e[u] = t0;     k = 3;     ack_d[u] = cur_we ? last_d[u] : ERRD;
      end else if (d + 1 <= T) begin
         stb_e[u] = t0 + d + 1; k = d + 3; ack_d[u] = cur_we ? last_d[u] : sw[i];
      end else begin
         stb_e[u] = t0 + T; k = T + 3; ack_d[u] = cur_we ? last_d[u] : ERRD;
      end
      ack_c[u]  = t0 + k - 1;
      last_d[u] = ack_d[u];
   endtask

   int t0;
   task automatic txn(input logic [35:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, input int d, input int mode);
      int ka, kb, kmax;
      cur_adr = adr; cur_dat = dat; cur_we = we; cur_sel = sel;
      t0 = cyc_n + 1;
      model_dut(0, MASK_A, d, mode, t0, ka);
      model_dut(1, MASK_B, d, mode, t0, kb);
      kmax = (ka > kb) ? ka : kb;
      dly = d;
      m_adr = adr; m_dat = dat; m_we = we; m_sel = sel; m_stb = 1'b1; m_cyc = 1'b1;
      if (mode == 0) begin
         while (cyc_n < t0 + kmax) @(negedge clk);
         m_stb = 1'b0; m_cyc = 1'b0;
         @(negedge clk);
      end else begin
         while (cyc_n < t0 + 2) @(negedge clk);
         m_stb = 1'b0; m_cyc = 1'b0;
         if (mode == 2) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_chk();
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
         @(negedge clk);
      end
   endtask

   int r0, a0, h0;
`ifdef WB_DECODER_STATUS_EN
   logic [15:0] ec_snap;
`endif

   initial begin
      rst_n = 1'b0;
      m_adr = '0; m_dat = '0; m_we = 1'b0; m_sel = '0; m_stb = 1'b0; m_cyc = 1'b0;
      repeat (3) @(negedge clk);
      rst_chk();
      rst_n   = 1'b1;
      started = 1'b1;
      @(negedge clk);

      // write to slave0, slave acks in its 3rd strobe cycle
      r0 = rise0_a; a0 = ackcnt[0];
      txn(36'h0_0000_0010, 1'b1, 32'h12345678, 4'hF, 2, 0);
      chk("wr0 strobe rises", 64'(rise0_a - r0), 64'(1));
      chk("wr0 ack pulses", 64'(ackcnt[0] - a0), 64'(1));
      chk("wr0 ack latency", 64'(ack_at[0] + 1 - t0), 64'(5));

      // slave3 read: real data on dut_a, unpopulated on dut_b
      txn(36'hC_0000_0004, 1'b0, 32'h0, 4'hF, 1, 0);
      chk("rd3 data a", 64'(ack_dat[0]), 64'(32'hCAFEF00D));
      chk("rd3 err data b", 64'(ack_dat[1]), 64'(32'hDEADBEEF));
      chk("rd3 err latency b", 64'(ack_at[1] + 1 - t0), 64'(3));
`ifdef WB_DECODER_STATUS_EN
      chk("rd3 err_count b", 64'(ec_b), 64'(1));
      chk("rd3 last_err_to b", 64'(lt_b), 64'(0));
`endif

      // region 2 read
      txn(36'h8_0000_0000, 1'b0, 32'h0, 4'hF, 0, 0);
      chk("rd2 data a", 64'(ack_dat[0]), 64'(32'h2222ABCD));
      chk("rd2 err data b", 64'(ack_dat[1]), 64'(32'hDEADBEEF));

      // slave1 never acks: watchdog
      h0 = hi1_a;
      txn(36'h4_0000_0000, 1'b0, 32'h0, 4'hF, NEVER, 0);
      chk("to strobe cycles", 64'(hi1_a - h0), 64'(8));
      chk("to ack latency", 64'(ack_at[0] + 1 - t0), 64'(11));
      chk("to data a", 64'(ack_dat[0]), 64'(32'hDEADBEEF));
`ifdef WB_DECODER_STATUS_EN
      chk("to last_err_to a", 64'(lt_a), 64'(1));
      chk("to last_err_adr a", 64'(la_a), 64'(36'h4_0000_0000));
      ec_snap = ec_a;
`endif

      // slave2 acks in the cycle the counter expires: ack wins
      txn(36'h8_0000_0008, 1'b0, 32'h0, 4'hF, T - 1, 0);
      chk("edge data a", 64'(ack_dat[0]), 64'(32'h2222ABCD));
      chk("edge ack latency", 64'(ack_at[0] + 1 - t0), 64'(10));
`ifdef WB_DECODER_STATUS_EN
      chk("edge err_count a", 64'(ec_a), 64'(ec_snap));
`endif

      txn(36'h4_0000_0100, 1'b1, 32'hA5A5A5A5, 4'h3, 0, 0);

      // master abort, then a normal write
      a0 = ackcnt[0];
      txn(36'h0_0000_0020, 1'b0, 32'h0, 4'hF, NEVER, 1);
      chk("abort no ack", 64'(ackcnt[0] - a0), 64'(0));
      txn(36'h0_0000_0030, 1'b1, 32'h0BADF00D, 4'h1, 1, 0);

      // reset while ACTIVE, then normal traffic
      a0 = ackcnt[0];
      txn(36'h4_0000_0040, 1'b0, 32'h0, 4'hF, NEVER, 2);
      chk("reset no ack", 64'(ackcnt[0] - a0), 64'(0));
      txn(36'h0_0000_0044, 1'b1, 32'h77778888, 4'hC, 0, 0);
      txn(36'h0_0000_0048, 1'b0, 32'h0, 4'hF, 0, 0);
      chk("post-reset rd0 a", 64'(ack_dat[0]), 64'(32'h00005A5A));

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
